// File: rtl/fp_add_seq_ctrl_if.sv
// Operand and result handshakes for the sequential FP32 adder.
// The master side supplies operands and accepts results. The slave side is the adder itself.
interface fp_add_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [2:0]  out_flags;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_flags
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_flags
    );
endinterface

// File: rtl/fp_add_seq_ctrl.sv
// Multi-cycle IEEE754 single-precision adder sequencer.
// The block unpacks both operands, aligns them one shift per cycle, then adds or subtracts.
// It normalizes one shift per cycle, rounds to nearest-even and returns the packed sum.
// Internal mantissa layout: [27] carry, [26] hidden, [25:3] fraction, [2:0] guard/round/sticky.
module fp_add_seq_ctrl #(
    parameter int unsigned MAX_ALIGN = 27,
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic             clk,
    input  logic             rst,
    fp_add_seq_ctrl_if.slave bus,
    output logic             busy,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADDSUB = 3'd3,
        S_NORM   = 3'd4,
        S_ROUND  = 3'd5,
        S_OUT    = 3'd6
    } state_t;

    localparam logic [7:0] MAX_ALIGN_C = MAX_ALIGN[7:0];

    state_t      state_q, state_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic [31:0] b_raw_q, b_raw_d;
    logic [36:0] op_a_q, op_a_d;        // {sign, exp, mant}
    logic [36:0] op_b_q, op_b_d;
    logic [7:0]  diff_q, diff_d;        // remaining alignment shifts
    logic        b_small_q, b_small_d;  // 1: B has the smaller (or equal) exponent
    logic        res_sign_q, res_sign_d;
    logic [9:0]  res_exp_q, res_exp_d;  // wide enough to see overflow past 255
    logic [27:0] res_mant_q, res_mant_d;
    logic        special_q, special_d;  // result already resolved during unpack
    logic [31:0] out_sum_q, out_sum_d;
    logic [2:0]  out_flags_q, out_flags_d;

    // Operand decode
    logic [7:0]  ea_f, eb_f, ea_eff, eb_eff;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic [36:0] op_a_unp, op_b_unp;

    assign ea_f   = a_raw_q[30:23];
    assign eb_f   = b_raw_q[30:23];
    // Subnormals use effective exponent 1 with the hidden bit clear.
    assign ea_eff = (ea_f == 8'd0) ? 8'd1 : ea_f;
    assign eb_eff = (eb_f == 8'd0) ? 8'd1 : eb_f;
    assign nan_a  = (&ea_f) & (|a_raw_q[22:0]);
    assign nan_b  = (&eb_f) & (|b_raw_q[22:0]);
    assign inf_a  = (&ea_f) & ~(|a_raw_q[22:0]);
    assign inf_b  = (&eb_f) & ~(|b_raw_q[22:0]);
    assign op_a_unp = {a_raw_q[31], ea_eff, 1'b0, (ea_f != 8'd0), a_raw_q[22:0], 3'b000};
    assign op_b_unp = {b_raw_q[31], eb_eff, 1'b0, (eb_f != 8'd0), b_raw_q[22:0], 3'b000};

    // Magnitude add/subtract of the aligned mantissas. An exact zero is forced to +0.
    logic [27:0] add_mant;
    logic        add_sign;
    always_comb begin
        add_mant = '0;
        add_sign = 1'b0;
        if (op_a_q[36] == op_b_q[36]) begin
            add_mant = op_a_q[27:0] + op_b_q[27:0];
            add_sign = op_a_q[36];
        end else if (op_a_q[27:0] >= op_b_q[27:0]) begin
            add_mant = op_a_q[27:0] - op_b_q[27:0];
            add_sign = op_a_q[36];
        end else begin
            add_mant = op_b_q[27:0] - op_a_q[27:0];
            add_sign = op_b_q[36];
        end
        if (add_mant == 28'd0) add_sign = 1'b0;
    end

    // Round-to-nearest-even and pack. A rounding carry renormalizes in place.
    logic        rnd_up;
    logic [24:0] rnd_sig;
    logic [9:0]  rnd_exp;
    logic [31:0] rnd_sum;
    logic [2:0]  rnd_flags;
    always_comb begin
        rnd_up  = res_mant_q[2] & (res_mant_q[1] | res_mant_q[0] | res_mant_q[3]);
        rnd_sig = {1'b0, res_mant_q[26:3]} + {24'd0, rnd_up};
        rnd_exp = res_exp_q;
        if (rnd_sig[24]) begin
            rnd_sig = {1'b0, rnd_sig[24:1]};
            rnd_exp = res_exp_q + 10'd1;
        end
        if (rnd_exp >= 10'd255) begin
            rnd_sum   = {res_sign_q, 8'hFF, 23'd0};
            rnd_flags = 3'b011;
        end else begin
            // Hidden bit clear here only happens at exp 1, which packs as a subnormal.
            rnd_sum   = {res_sign_q, (rnd_sig[23] ? rnd_exp[7:0] : 8'h00), rnd_sig[22:0]};
            rnd_flags = {2'b00, |res_mant_q[2:0]};
        end
    end

    // Next-state and datapath updates. Each state does one step of the operation.
    logic [27:0] m_small, m_shift;
    always_comb begin
        state_d     = state_q;
        a_raw_d     = a_raw_q;
        b_raw_d     = b_raw_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        diff_d      = diff_q;
        b_small_d   = b_small_q;
        res_sign_d  = res_sign_q;
        res_exp_d   = res_exp_q;
        res_mant_d  = res_mant_q;
        special_d   = special_q;
        out_sum_d   = out_sum_q;
        out_flags_d = out_flags_q;
        m_small     = b_small_q ? op_b_q[27:0] : op_a_q[27:0];
        m_shift     = m_small;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_raw_d = bus.in_a;
                    b_raw_d = bus.in_b;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                special_d = 1'b0;
                // Special results skip the arithmetic but still pass through ROUND.
                // This gives them a fixed two-cycle latency.
                if (nan_a || nan_b || (inf_a && inf_b && (a_raw_q[31] != b_raw_q[31]))) begin
                    special_d   = 1'b1;
                    out_sum_d   = CANON_NAN;
                    out_flags_d = 3'b100;
                    state_d     = S_ROUND;
                end else if (inf_a) begin
                    special_d   = 1'b1;
                    out_sum_d   = a_raw_q;
                    out_flags_d = 3'b000;
                    state_d     = S_ROUND;
                end else if (inf_b) begin
                    special_d   = 1'b1;
                    out_sum_d   = b_raw_q;
                    out_flags_d = 3'b000;
                    state_d     = S_ROUND;
                end else begin
                    op_a_d = op_a_unp;
                    op_b_d = op_b_unp;
                    if (ea_eff >= eb_eff) begin
                        diff_d    = ea_eff - eb_eff;
                        b_small_d = 1'b1;
                    end else begin
                        diff_d    = eb_eff - ea_eff;
                        b_small_d = 1'b0;
                    end
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (diff_q == 8'd0) begin
                    state_d = S_ADDSUB;
                end else if (diff_q > MAX_ALIGN_C) begin
                    // Everything would shift out, so only the sticky bit survives.
                    m_shift = {27'd0, |m_small};
                    diff_d  = 8'd0;
                    state_d = S_ADDSUB;
                end else begin
                    m_shift = {1'b0, m_small[27:2], m_small[1] | m_small[0]};
                    diff_d  = diff_q - 8'd1;
                    if (diff_q == 8'd1) state_d = S_ADDSUB;
                end
                if (b_small_q) op_b_d[27:0] = m_shift;
                else           op_a_d[27:0] = m_shift;
            end
            S_ADDSUB: begin
                res_mant_d = add_mant;
                res_sign_d = add_sign;
                res_exp_d  = {2'b00, (b_small_q ? op_a_q[35:28] : op_b_q[35:28])};
                state_d    = S_NORM;
            end
            S_NORM: begin
                if (res_mant_q[27]) begin
                    res_mant_d = {1'b0, res_mant_q[27:2], res_mant_q[1] | res_mant_q[0]};
                    res_exp_d  = res_exp_q + 10'd1;
                    state_d    = S_ROUND;
                end else if (!res_mant_q[26] && (res_exp_q > 10'd1)) begin
                    res_mant_d = {res_mant_q[26:0], 1'b0};
                    res_exp_d  = res_exp_q - 10'd1;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (!special_q) begin
                    out_sum_d   = rnd_sum;
                    out_flags_d = rnd_flags;
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers. Reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_raw_q     <= '0;
            b_raw_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            diff_q      <= '0;
            b_small_q   <= 1'b0;
            res_sign_q  <= 1'b0;
            res_exp_q   <= '0;
            res_mant_q  <= '0;
            special_q   <= 1'b0;
            out_sum_q   <= '0;
            out_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            a_raw_q     <= a_raw_d;
            b_raw_q     <= b_raw_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            diff_q      <= diff_d;
            b_small_q   <= b_small_d;
            res_sign_q  <= res_sign_d;
            res_exp_q   <= res_exp_d;
            res_mant_q  <= res_mant_d;
            special_q   <= special_d;
            out_sum_q   <= out_sum_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_flags = out_flags_q;
    assign busy          = (state_q != S_IDLE);
    assign state_o       = state_q;

endmodule

// File: tb/tb_fp_add_seq_ctrl.sv
// Directed bench for fp_add_seq_ctrl. It covers sums, flags and latency for normal,
// special, subnormal and rounding cases, plus output hold and mid-operation reset.
module tb_fp_add_seq_ctrl;
    logic       clk;
    logic       rst;
    logic       busy;
    logic [2:0] state_o;
    int         checks;
    int         failures;

    fp_add_seq_ctrl_if bus();

    fp_add_seq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an operand pair and return one time unit after the accepting edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges from the accepting edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 1000) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic accept_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready got %0b exp 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0)  begin failures++; $display("FAIL reset_out_valid got %0b exp 0", bus.out_valid); end
        checks++; if (busy !== 1'b0)           begin failures++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (bus.out_sum !== 32'h0)   begin failures++; $display("FAIL reset_out_sum got %h exp 0", bus.out_sum); end
        checks++; if (bus.out_flags !== 3'b0)  begin failures++; $display("FAIL reset_out_flags got %b exp 000", bus.out_flags); end
        checks++; if (state_o !== 3'd0)        begin failures++; $display("FAIL reset_state got %0d exp 0", state_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Run the table of directed vectors: sum, flags and latency each.
    task automatic test_vectors();
        logic [31:0] va [15];
        logic [31:0] vb [15];
        logic [31:0] vs [15];
        logic [2:0]  vf [15];
        int          vl [15];
        int          lat;
        // 1.0 + 1.0
        va[0]  = 32'h3F800000; vb[0]  = 32'h3F800000; vs[0]  = 32'h40000000; vf[0]  = 3'b000; vl[0]  = 5;
        // 1.0 + -1.0: exact zero, normalizes down to exp 1 (126 shifts + exit cycle)
        va[1]  = 32'h3F800000; vb[1]  = 32'hBF800000; vs[1]  = 32'h00000000; vf[1]  = 3'b000; vl[1]  = 131;
        // overflow to +Inf
        va[2]  = 32'h7F7FFFFF; vb[2]  = 32'h7F7FFFFF; vs[2]  = 32'h7F800000; vf[2]  = 3'b011; vl[2]  = 5;
        // Inf + -Inf -> canonical NaN, bypass
        va[3]  = 32'h7F800000; vb[3]  = 32'hFF800000; vs[3]  = 32'h7FC00000; vf[3]  = 3'b100; vl[3]  = 2;
        // NaN input
        va[4]  = 32'h7FC00001; vb[4]  = 32'h3F800000; vs[4]  = 32'h7FC00000; vf[4]  = 3'b100; vl[4]  = 2;
        // Inf + finite -> that Inf
        va[5]  = 32'h3F800000; vb[5]  = 32'hFF800000; vs[5]  = 32'hFF800000; vf[5]  = 3'b000; vl[5]  = 2;
        // subnormals
        va[6]  = 32'h00000001; vb[6]  = 32'h00000001; vs[6]  = 32'h00000002; vf[6]  = 3'b000; vl[6]  = 5;
        va[7]  = 32'h00400000; vb[7]  = 32'h00400000; vs[7]  = 32'h00800000; vf[7]  = 3'b000; vl[7]  = 5;
        // d=30 collapses to sticky in one ALIGN cycle
        va[8]  = 32'h3F800000; vb[8]  = 32'h30800000; vs[8]  = 32'h3F800000; vf[8]  = 3'b001; vl[8]  = 5;
        // tie, even lsb -> no round-up; 24 ALIGN cycles
        va[9]  = 32'h3F800000; vb[9]  = 32'h33800000; vs[9]  = 32'h3F800000; vf[9]  = 3'b001; vl[9]  = 28;
        // tie, odd lsb -> round up
        va[10] = 32'h3F800001; vb[10] = 32'h33800000; vs[10] = 32'h3F800002; vf[10] = 3'b001; vl[10] = 28;
        // 1.0 + 2.0 = 3.0, A shifted once
        va[11] = 32'h3F800000; vb[11] = 32'h40000000; vs[11] = 32'h40400000; vf[11] = 3'b000; vl[11] = 5;
        // 2.0 - 1.0 = 1.0, one left shift in NORM
        va[12] = 32'h40000000; vb[12] = 32'hBF800000; vs[12] = 32'h3F800000; vf[12] = 3'b000; vl[12] = 6;
        // 1.0 - 2.0 = -1.0, sign from larger B
        va[13] = 32'h3F800000; vb[13] = 32'hC0000000; vs[13] = 32'hBF800000; vf[13] = 3'b000; vl[13] = 6;
        // -1.5 + -1.5 = -3.0
        va[14] = 32'hBFC00000; vb[14] = 32'hBFC00000; vs[14] = 32'hC0400000; vf[14] = 3'b000; vl[14] = 5;
        for (int i = 0; i < 15; i++) begin
            launch(va[i], vb[i]);
            wait_out(lat);
            checks++; if (bus.out_sum !== vs[i])   begin failures++; $display("FAIL vec%0d_sum got %h exp %h", i, bus.out_sum, vs[i]); end
            checks++; if (bus.out_flags !== vf[i]) begin failures++; $display("FAIL vec%0d_flags got %b exp %b", i, bus.out_flags, vf[i]); end
            checks++; if (lat != vl[i])            begin failures++; $display("FAIL vec%0d_latency got %0d exp %0d", i, lat, vl[i]); end
            accept_out();
        end
    endtask

    // Result must hold while out_ready is low, and no operand may be taken meanwhile.
    task automatic test_hold();
        int lat;
        launch(32'h3F800000, 32'h3F800000);
        wait_out(lat);
        bus.in_a     = 32'h40000000;
        bus.in_b     = 32'h40000000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++; if (bus.out_valid !== 1'b1)      begin failures++; $display("FAIL hold%0d_valid got %0b exp 1", i, bus.out_valid); end
            checks++; if (bus.out_sum !== 32'h40000000) begin failures++; $display("FAIL hold%0d_sum got %h exp 40000000", i, bus.out_sum); end
            checks++; if (bus.in_ready !== 1'b0)       begin failures++; $display("FAIL hold%0d_in_ready got %0b exp 0", i, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        accept_out();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_release_valid got %0b exp 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL hold_release_ready got %0b exp 1", bus.in_ready); end
    endtask

    // Reset during NORM aborts with no output, and the next operation is unaffected.
    task automatic test_reset_mid();
        int n;
        int lat;
        launch(32'h3F800000, 32'hBF800000);
        n = 0;
        while (state_o !== 3'd4 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (state_o !== 3'd4) begin failures++; $display("FAIL midrst_reach_norm got %0d exp 4", state_o); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got %0b exp 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1)  begin failures++; $display("FAIL midrst_in_ready got %0b exp 1", bus.in_ready); end
        checks++; if (busy !== 1'b0)          begin failures++; $display("FAIL midrst_busy got %0b exp 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        launch(32'h3F800000, 32'h3F800000);
        wait_out(lat);
        checks++; if (bus.out_sum !== 32'h40000000) begin failures++; $display("FAIL midrst_next_sum got %h exp 40000000", bus.out_sum); end
        checks++; if (bus.out_flags !== 3'b000)     begin failures++; $display("FAIL midrst_next_flags got %b exp 000", bus.out_flags); end
        checks++; if (lat != 5)                     begin failures++; $display("FAIL midrst_next_latency got %0d exp 5", lat); end
        accept_out();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
